// File: rtl/and5_share_ctrl.sv
// Round-robin sequencer that time-shares one combinational AND datapath among
// several requesters and returns each result with its owner ID over valid/ready.
module and5_share_ctrl #(
    parameter int NREQ = 4,
    parameter int W    = 5,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   a_in,
    input  logic [NREQ*W-1:0]   b_in,
    output logic [NREQ-1:0]     gnt,
    output logic [W-1:0]        and_a,
    output logic [W-1:0]        and_b,
    input  logic [W-1:0]        and_res,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_data,
    input  logic                rsp_ready,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [W-1:0]      and_a_q, and_a_d;
    logic [W-1:0]      and_b_q, and_b_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [W-1:0]      rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              win_found_s;
    logic [IDW-1:0]    win_id_s;
    logic [IDW-1:0]    idx_s;
    logic [NREQ-1:0]   gnt_s;
    logic              busy_s;

    // Round-robin search: first set request bit starting at ptr, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        idx_s       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = IDW'((int'(ptr_q) + k) % NREQ);
            if (!win_found_s && req[idx_s]) begin
                win_found_s = 1'b1;
                win_id_s    = idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> RESP sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath updates; operands and response fields hold unless loaded.
    always_comb begin
        ptr_d       = ptr_q;
        and_a_d     = and_a_q;
        and_b_d     = and_b_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    and_a_d  = a_in[win_id_s*W +: W];
                    and_b_d  = b_in[win_id_s*W +: W];
                    rsp_id_d = win_id_s;
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                rsp_data_d  = and_res;
                ptr_d       = IDW'((int'(rsp_id_q) + 1) % NREQ);
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end else begin
                    rsp_valid_d = rsp_valid_q;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Grant decodes only from registered state so it cannot glitch with req.
    always_comb begin
        gnt_s  = '0;
        busy_s = (state_q != ST_IDLE);
        if (state_q == ST_ISSUE) begin
            gnt_s[rsp_id_q] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            and_a_q     <= '0;
            and_b_q     <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            and_a_q     <= and_a_d;
            and_b_q     <= and_b_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign gnt       = gnt_s;
    assign busy      = busy_s;
    assign and_a     = and_a_q;
    assign and_b     = and_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: doc/and5_share_ctrl.md
Name: and5_share_ctrl

Overview:
- Sequencer/arbiter that time-shares one 5-bit C2-cell AND datapath among NREQ requesters.
- Arbitrates round-robin, latches the winner's operands and drives them to the shared unit.
- Captures the unit's result and returns it with requester ID over a valid/ready response channel.
- Sits between client blocks and the single shared AND instance, which stays purely combinational.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 so IDW = 2.
- W, 5, operand/result width; matches the shared AND datapath.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- req  input  NREQ  per-requester request level.
- a_in  input  NREQ*W  operand A bus; requester i occupies bits [i*W +: W].
- b_in  input  NREQ*W  operand B bus; same packing as a_in.
- gnt  output  NREQ  one-hot grant, high for exactly one cycle per accepted request.
- and_a  output  W  operand A to the shared AND unit.
- and_b  output  W  operand B to the shared AND unit.
- and_res  input  W  result from the shared AND unit (combinational of and_a, and_b).
- rsp_valid  output  1  response available.
- rsp_id  output  2  index of the requester that owns rsp_data.
- rsp_data  output  W  captured AND result.
- rsp_ready  input  1  consumer accepts the response.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ptr=0, gnt=0, and_a=0, and_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0. Reset mid-operation aborts the operation; that request is lost.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise choose winner w = first set bit of req searching ptr, ptr+1, ... (mod NREQ).
  - Register and_a<=a_in[w], and_b<=b_in[w], rsp_id<=w; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - gnt[rsp_id]=1, all other gnt bits 0.
  - At the clock edge, rsp_data<=and_res, ptr<=(rsp_id+1) mod NREQ; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_data are held stable.
  - On an edge with rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
  - No new arbitration while in RESP (backpressure holds the unit).
- Latency: req sampled at edge k -> gnt high in cycle k..k+1 -> rsp_valid high from edge k+1.
- Minimum spacing between grants is 3 cycles (IDLE, ISSUE, RESP each 1 cycle when rsp_ready=1).
- req/operands are sampled only in IDLE. Changes during ISSUE/RESP are ignored. A requester may drop req after its gnt pulse.
- A requester that keeps req high after its gnt is re-arbitrated normally. Round-robin gives the other pending requesters priority first.
- and_a/and_b hold their last values after the operation; no clear to 0 except on reset.
- gnt is combinational from state/rsp_id only, never from req. It is glitch-free relative to clk.

Test Plan:
- Reset then single request: req=4'b0100, a_in[2]=5'b10110, b_in[2]=5'b01111, rsp_ready=1 -> gnt=4'b0100 for 1 cycle; rsp_valid 1 cycle later with rsp_id=2, rsp_data=5'b00110; busy back to 0 after the handshake.
- Round-robin fairness: req=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0 with exactly 3 cycles between gnt pulses.
- Backpressure: rsp_ready=0 for 5 cycles in RESP, operands changed meanwhile -> rsp_valid stays 1, rsp_data/rsp_id unchanged, no gnt pulse; release -> IDLE next edge.
- Pointer skip: after granting 1, req=4'b0011 -> next grant is 0 (ptr=2 wraps past empty 2,3), then 1.
- Reset mid-operation: assert rst=0 while in ISSUE with req=4'b1000 -> all outputs 0 immediately, ptr=0. After release with req=4'b1001 the grant goes to 0.
- Data corners: a=5'b11111,b=5'b11111 -> 5'b11111; a=5'b11111,b=5'b00000 -> 5'b00000; a=5'b10101,b=5'b01010 -> 5'b00000.
